// File: rtl/instruction_fetch.sv
// Byte-serial instruction fetch: owns the 8-bit PC, gathers 4 bytes per instruction and holds them until accepted.
// Optional feature: define IFETCH_PREFETCH_EN to add a 4-byte shadow buffer that prefetches the next instruction during HOLD.
module instruction_fetch #(
  parameter logic [7:0] RESET_PC    = 8'h00,
  parameter int         INSTR_BYTES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       mem_req,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rdata,
  input  logic       mem_valid,
  output logic [7:0] opcode1,
  output logic [7:0] opcode2,
  output logic [7:0] opcode3,
  output logic [7:0] opcode4,
  output logic       instr_valid,
  input  logic       instr_ready,
  input  logic       pc_load,
  input  logic [7:0] cnt_input,
  output logic [7:0] cnt_output
);

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [1:0] LAST_IDX = 2'(INSTR_BYTES - 1);
  localparam logic [7:0] PC_STEP  = 8'(INSTR_BYTES);

  state_t     state_r, state_s;
  logic [7:0] pc_r, pc_s;
  logic [1:0] byte_idx_r, byte_idx_s;
  logic [7:0] op_r [4];
  logic [7:0] op_s [4];
  logic       instr_valid_r, instr_valid_s;
  logic       mem_req_r, mem_req_s;
  logic [7:0] mem_addr_r, mem_addr_s;
  logic       accept_s;
  logic       take_s;

`ifdef IFETCH_PREFETCH_EN
  logic [7:0] sh_r [4];
  logic [7:0] sh_s [4];
  logic [2:0] sh_cnt_r, sh_cnt_s;
`endif

  assign accept_s = instr_valid_r && instr_ready;
  assign take_s   = mem_req_r && mem_valid;

  // Next-state, PC and next registered memory-request computation
  always_comb begin
    state_s       = state_r;
    pc_s          = pc_r;
    byte_idx_s    = byte_idx_r;
    op_s          = op_r;
    instr_valid_s = instr_valid_r;
`ifdef IFETCH_PREFETCH_EN
    sh_s     = sh_r;
    sh_cnt_s = sh_cnt_r;
    // Prefetch capture happens first so an accept in the same cycle sees this byte
    if ((state_r == HOLD) && take_s && (sh_cnt_r < 3'd4)) begin
      sh_s[sh_cnt_r[1:0]] = mem_rdata;
      sh_cnt_s            = sh_cnt_r + 3'd1;
    end else begin
      sh_cnt_s = sh_cnt_r;
    end
`endif
    if (pc_load) begin
      pc_s          = cnt_input;
      byte_idx_s    = 2'd0;
      state_s       = FETCH;
      instr_valid_s = 1'b0;
`ifdef IFETCH_PREFETCH_EN
      sh_cnt_s = 3'd0;
`endif
    end else if (accept_s) begin
      pc_s          = pc_r + PC_STEP;
      byte_idx_s    = 2'd0;
      state_s       = FETCH;
      instr_valid_s = 1'b0;
`ifdef IFETCH_PREFETCH_EN
      if (sh_cnt_s == 3'd4) begin
        op_s          = sh_s;
        state_s       = HOLD;
        instr_valid_s = 1'b1;
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (3'(i) < sh_cnt_s) begin
            op_s[i] = sh_s[i];
          end else begin
            op_s[i] = op_r[i];
          end
        end
        byte_idx_s = sh_cnt_s[1:0];
      end
      sh_cnt_s = 3'd0;
`endif
    end else if ((state_r == FETCH) && take_s) begin
      op_s[byte_idx_r] = mem_rdata;
      if (byte_idx_r == LAST_IDX) begin
        state_s       = HOLD;
        instr_valid_s = 1'b1;
        byte_idx_s    = 2'd0;
      end else begin
        byte_idx_s = byte_idx_r + 2'd1;
      end
    end else begin
      state_s = state_r;
    end

`ifdef IFETCH_PREFETCH_EN
    if (state_s == FETCH) begin
      mem_req_s  = 1'b1;
      mem_addr_s = pc_s + {6'd0, byte_idx_s};
    end else begin
      mem_req_s  = (sh_cnt_s < 3'd4);
      mem_addr_s = pc_s + PC_STEP + {6'd0, sh_cnt_s[1:0]};
    end
`else
    mem_req_s  = (state_s == FETCH);
    mem_addr_s = pc_s + {6'd0, byte_idx_s};
`endif
  end

  // State, PC, instruction and request registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= FETCH;
      pc_r          <= RESET_PC;
      byte_idx_r    <= 2'd0;
      instr_valid_r <= 1'b0;
      mem_req_r     <= 1'b0;
      mem_addr_r    <= RESET_PC;
      for (int i = 0; i < 4; i++) begin
        op_r[i] <= 8'h00;
      end
`ifdef IFETCH_PREFETCH_EN
      sh_cnt_r <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        sh_r[i] <= 8'h00;
      end
`endif
    end else begin
      state_r       <= state_s;
      pc_r          <= pc_s;
      byte_idx_r    <= byte_idx_s;
      instr_valid_r <= instr_valid_s;
      mem_req_r     <= mem_req_s;
      mem_addr_r    <= mem_addr_s;
      for (int i = 0; i < 4; i++) begin
        op_r[i] <= op_s[i];
      end
`ifdef IFETCH_PREFETCH_EN
      sh_cnt_r <= sh_cnt_s;
      for (int i = 0; i < 4; i++) begin
        sh_r[i] <= sh_s[i];
      end
`endif
    end
  end

  assign mem_req     = mem_req_r;
  assign mem_addr    = mem_addr_r;
  assign opcode1     = op_r[0];
  assign opcode2     = op_r[1];
  assign opcode3     = op_r[2];
  assign opcode4     = op_r[3];
  assign instr_valid = instr_valid_r;
  assign cnt_output  = pc_r;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch (default build): a table of fetch/hold/accept transactions plus hand sequences.
module tb_instruction_fetch;

  logic       clk;
  logic       rst_n;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata;
  logic       mem_valid;
  logic [7:0] opcode1, opcode2, opcode3, opcode4;
  logic       instr_valid;
  logic       instr_ready;
  logic       pc_load;
  logic [7:0] cnt_input;
  logic [7:0] cnt_output;

  int checks = 0;
  int errors = 0;
  int waits  = 0;
  int wcnt;

  instruction_fetch #(.RESET_PC(8'h00), .INSTR_BYTES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .opcode1(opcode1), .opcode2(opcode2), .opcode3(opcode3), .opcode4(opcode4),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .pc_load(pc_load), .cnt_input(cnt_input), .cnt_output(cnt_output)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: byte at address a is a+1; each byte answered after 'waits' stall cycles
  assign mem_valid = mem_req && (wcnt >= waits);
  assign mem_rdata = mem_addr + 8'd1;

  // Wait-state counter of the memory model
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wcnt <= 0;
    else if (!mem_req || mem_valid) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  typedef struct {
    int         waits;
    logic [7:0] pc;
    int         lat;
    int         hold;
    logic       ld;
    logic [7:0] tgt;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starting at the fetch-start cycle, run until instr_valid and check the result
  task automatic run_fetch(input logic [7:0] pc, input int lat);
    int n = 0;
    int cyc = 0;
    int stab_err = 0;
    logic [7:0] a [8];
    logic       pend = 1'b0;
    logic [7:0] paddr = 8'h00;
    while (!instr_valid && cyc < 200) begin
      if (pend && mem_req && (mem_addr != paddr)) stab_err++;
      if (mem_req && mem_valid) begin
        if (n < 8) a[n] = mem_addr;
        n++;
      end
      pend  = mem_req && !mem_valid;
      paddr = mem_addr;
      step();
      cyc++;
    end
    chk("fetch_latency", 32'(cyc), 32'(lat));
    chk("fetch_nbytes", 32'(n), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < n) chk("fetch_addr", {24'd0, a[k]}, {24'd0, pc + 8'(k)});
    end
    chk("addr_stable", 32'(stab_err), 32'd0);
    chk("opcode1", {24'd0, opcode1}, {24'd0, pc + 8'd1});
    chk("opcode2", {24'd0, opcode2}, {24'd0, pc + 8'd2});
    chk("opcode3", {24'd0, opcode3}, {24'd0, pc + 8'd3});
    chk("opcode4", {24'd0, opcode4}, {24'd0, pc + 8'd4});
    chk("cnt_output", {24'd0, cnt_output}, {24'd0, pc});
    chk("req_low_hold", {31'd0, mem_req}, 32'd0);
  endtask

  task automatic hold_cycles(input logic [7:0] pc, input int cyc);
    for (int k = 0; k < cyc; k++) begin
      step();
      chk("hold_valid", {31'd0, instr_valid}, 32'd1);
      chk("hold_req", {31'd0, mem_req}, 32'd0);
      chk("hold_cnt", {24'd0, cnt_output}, {24'd0, pc});
      chk("hold_ops", {opcode1, opcode2, opcode3, opcode4},
          {pc + 8'd1, pc + 8'd2, pc + 8'd3, pc + 8'd4});
    end
  endtask

  task automatic accept(input logic [7:0] pc, input logic ld, input logic [7:0] tgt, input int next_waits);
    logic [7:0] npc;
    npc = ld ? tgt : pc + 8'd4;
    instr_ready = 1'b1;
    pc_load     = ld;
    cnt_input   = tgt;
    waits       = next_waits;
    step();
    instr_ready = 1'b0;
    pc_load     = 1'b0;
    chk("acc_bubble", {31'd0, instr_valid}, 32'd0);
    chk("acc_cnt", {24'd0, cnt_output}, {24'd0, npc});
    chk("acc_req", {31'd0, mem_req}, 32'd1);
    chk("acc_addr", {24'd0, mem_addr}, {24'd0, npc});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{waits: 0, pc: 8'h00, lat: 4,  hold: 5, ld: 1'b1, tgt: 8'h20};
    vecs[1] = '{waits: 0, pc: 8'h20, lat: 4,  hold: 0, ld: 1'b1, tgt: 8'hFC};
    vecs[2] = '{waits: 0, pc: 8'hFC, lat: 4,  hold: 1, ld: 1'b0, tgt: 8'h00};
    vecs[3] = '{waits: 3, pc: 8'h00, lat: 16, hold: 0, ld: 1'b1, tgt: 8'hFE};
    vecs[4] = '{waits: 0, pc: 8'hFE, lat: 4,  hold: 2, ld: 1'b0, tgt: 8'h00};
    vecs[5] = '{waits: 0, pc: 8'h02, lat: 4,  hold: 0, ld: 1'b0, tgt: 8'h00};

    rst_n       = 1'b0;
    instr_ready = 1'b0;
    pc_load     = 1'b0;
    cnt_input   = 8'h00;
    waits       = vecs[0].waits;
    #12;
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_ops", {opcode1, opcode2, opcode3, opcode4}, 32'd0);
    chk("rst_cnt", {24'd0, cnt_output}, 32'd0);
    #6 rst_n = 1'b1;
    step();
    chk("first_req", {31'd0, mem_req}, 32'd1);
    chk("first_addr", {24'd0, mem_addr}, 32'd0);

    for (int i = 0; i < 6; i++) begin
      run_fetch(vecs[i].pc, vecs[i].lat);
      hold_cycles(vecs[i].pc, vecs[i].hold);
      accept(vecs[i].pc, vecs[i].ld, vecs[i].tgt, (i < 5) ? vecs[i + 1].waits : 0);
    end

    // Fetch at 06 in progress; redirect while byte 2 (addr 08) is being returned
    step();
    step();
    chk("redir_pre_addr", {24'd0, mem_addr}, 32'h08);
    chk("redir_pre_valid", {31'd0, mem_valid}, 32'd1);
    pc_load   = 1'b1;
    cnt_input = 8'h40;
    step();
    pc_load = 1'b0;
    chk("redir_addr", {24'd0, mem_addr}, 32'h40);
    chk("redir_cnt", {24'd0, cnt_output}, 32'h40);
    chk("redir_ivalid", {31'd0, instr_valid}, 32'd0);
    run_fetch(8'h40, 4);
    accept(8'h40, 1'b0, 8'h00, 0);

    // Asynchronous reset in the middle of the fetch at 44
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", {31'd0, mem_req}, 32'd0);
    chk("arst_valid", {31'd0, instr_valid}, 32'd0);
    chk("arst_ops", {opcode1, opcode2, opcode3, opcode4}, 32'd0);
    chk("arst_cnt", {24'd0, cnt_output}, 32'd0);
    chk("arst_addr", {24'd0, mem_addr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    run_fetch(8'h00, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
